countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable 8-bit down-counter with a three-state run controller, one-cycle terminal-count pulse, and two hex seven-segment outputs. It is the count-down counterpart of the lab's up-counting T-flip-flop counter. It reuses the same switch/key-driven board wiring, so a loaded value can be watched running down to zero on HEX1:HEX0. It sits between the board inputs (switches, keys) and the two displays.

## Interface
- AUTO_RELOAD, 0, when 1 a terminal count reloads the last loaded value and keeps running; when 0 the counter stops in DONE.
- clk  input  1  rising-edge clock (board key or system clock).
- clear_b  input  1  asynchronous, active-low reset; one clock, no other reset.
- enable  input  1  decrement request; sampled on rising clk.
- load  input  1  synchronous load strobe; sampled on rising clk.
- load_value  input  8  value captured when load=1.
- q  output  8  current count.
- tc  output  1  registered terminal-count pulse, one cycle wide.
- running  output  1  high while in RUN.
- hex0  output  7  active-low segments for q[3:0]; bit0=a … bit6=g.
- hex1  output  7  active-low segments for q[7:4]; same encoding.

## Operation
- States: IDLE, RUN, DONE.
- Reset (clear_b=0, asynchronous) forces the following, held until clear_b=1:
  - state=IDLE, q=0, reload register=0, tc=0, running=0.
  - hex0=hex1=7'b1000000 (digit 0).
- Priority on each edge: load > enable > hold.
- load=1, any state:
  - q<=load_value and reload register<=load_value.
  - Next state is RUN if load_value≠0, else DONE.
  - tc<=0.
- IDLE: q holds; enable is ignored.
- RUN, enable=1:
  - If q>1: q<=q−1.
  - If q==1: q<=0 and tc<=1.
    - AUTO_RELOAD=0: next state DONE.
    - AUTO_RELOAD=1: if reload≠0, q<=reload instead of 0, tc<=1, and state stays RUN.
- RUN, enable=0: q holds, tc<=0.
- DONE: q holds at 0. enable is ignored with no wrap to 8'hFF. Only load or reset leaves DONE.
- tc is 0 on every edge not listed above.
- Arithmetic: unsigned 8-bit. The counter never decrements below 0 and never wraps.
- Segment decode: combinational from q, standard hex 0–F.
  - Lowercase b and d; uppercase A, C, E, F.
  - Examples: 1→7'b1111001, 8→7'b0000000, A→7'b0001000, F→7'b0001110.

## Timing
- load→q: q shows load_value after the same rising edge; latency 1 clock.
- enable→q: one decrement per rising edge with enable=1 in RUN.
- tc rises on the edge where q becomes 0 (or reloads). It falls on the next edge unless a new terminal count occurs.
- running is a registered state decode and changes on the same edge as state.
- hex0/hex1 follow q combinationally, with no added latency.
- Reset asserted mid-count clears all state immediately; no pending tc survives.
- load and enable in the same cycle: load wins, with no decrement that cycle.
- load_value=1 followed by enable: terminal count on the next enabled edge.

## Configuration
- COUNTDOWN_SEG_EN defined: hex0/hex1 carry the decoded digits as above.
- COUNTDOWN_SEG_EN undefined:
  - The decoder is not compiled.
  - hex0/hex1 are tied to 7'b1111111 (all segments off).
  - All other behaviour is unchanged.

## Test plan
- Reset mid-run: load 8'h20, enable 5 clocks, pulse clear_b low between edges → immediately q=0, state IDLE, hex0=hex1=7'b1000000, tc=0.
- Basic run, AUTO_RELOAD=0: load 8'h03, enable held → q 3,2,1,0 on successive edges; tc=1 for exactly one cycle as q hits 0; running 1→0; further enables keep q=0.
- Priority: load 8'h05 then assert load=1 (load_value 8'h09) together with enable → q=9, no decrement that cycle.
- Zero load: load 8'h00 → state DONE, running=0, tc never asserts; enable leaves q=0.
- AUTO_RELOAD=1: load 8'h02, enable for 6 clocks → q 2,1,2,1,2,1; tc pulses on each 1→2 edge; running stays 1.
- Display: load 8'hAF with COUNTDOWN_SEG_EN → hex1=7'b0001000, hex0=7'b0001110; without the macro both read 7'b1111111.

Source files
------------

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control and display bundle for countdown_timer.
// master = board side (switches/keys/displays), slave = the timer itself.
interface countdown_timer_if;
   logic       enable;
   logic       load;
   logic [7:0] load_value;
   logic [7:0] q;
   logic       tc;
   logic       running;
   logic [6:0] hex0;
   logic [6:0] hex1;

   modport master (
      output enable, load, load_value,
      input  q, tc, running, hex0, hex1
   );

   modport slave (
      input  enable, load, load_value,
      output q, tc, running, hex0, hex1
   );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: loadable 8-bit down-counter with IDLE/RUN/DONE control,
// one-cycle registered terminal-count pulse and two hex seven-segment outputs.
// Optional feature macro COUNTDOWN_SEG_EN: when defined, hex0/hex1 show the
// decoded digits of q; when undefined, the decoder is left out and both
// displays are blanked (all segments off).
// AUTO_RELOAD=1 restarts from the last loaded value on terminal count.
module countdown_timer #(
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic               clk,
   input  logic               clear_b,
   countdown_timer_if.slave   bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0] state_r, state_s;
   logic [7:0] q_r, q_s;
   logic [7:0] reload_r, reload_s;
   logic       tc_r, tc_s;
   logic       running_r;

`ifdef COUNTDOWN_SEG_EN
   // Active-low hex digit decode, bit0=a .. bit6=g; b and d are lowercase.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         4'hF:    s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction
`endif

   // Next-state logic: load beats enable beats hold; tc is a pulse by default.
   always_comb begin
      state_s  = state_r;
      q_s      = q_r;
      reload_s = reload_r;
      tc_s     = 1'b0;
      if (bus.load) begin
         q_s      = bus.load_value;
         reload_s = bus.load_value;
         if (bus.load_value != 8'h00) begin
            state_s = ST_RUN;
         end else begin
            state_s = ST_DONE;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               q_s = q_r;
            end
            ST_RUN: begin
               if (bus.enable) begin
                  if (q_r > 8'h01) begin
                     q_s = q_r - 8'h01;
                  end else if (q_r == 8'h01) begin
                     tc_s = 1'b1;
                     if (AUTO_RELOAD && (reload_r != 8'h00)) begin
                        q_s = reload_r;
                     end else begin
                        q_s     = 8'h00;
                        state_s = ST_DONE;
                     end
                  end else begin
                     // A zero count in RUN is unreachable; settle in DONE
                     // rather than wrapping to 8'hFF.
                     q_s     = 8'h00;
                     state_s = ST_DONE;
                  end
               end else begin
                  q_s = q_r;
               end
            end
            ST_DONE: begin
               q_s = 8'h00;
            end
            default: begin
               state_s = ST_IDLE;
               q_s     = 8'h00;
            end
         endcase
      end
   end

   // State, count, reload value, tc pulse and running decode registers.
   always_ff @(posedge clk or negedge clear_b) begin
      if (!clear_b) begin
         state_r   <= ST_IDLE;
         q_r       <= 8'h00;
         reload_r  <= 8'h00;
         tc_r      <= 1'b0;
         running_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         q_r       <= q_s;
         reload_r  <= reload_s;
         tc_r      <= tc_s;
         running_r <= (state_s == ST_RUN);
      end
   end

   assign bus.q       = q_r;
   assign bus.tc      = tc_r;
   assign bus.running = running_r;

`ifdef COUNTDOWN_SEG_EN
   assign bus.hex0 = seg7(q_r[3:0]);
   assign bus.hex1 = seg7(q_r[7:4]);
`else
   assign bus.hex0 = 7'b1111111;
   assign bus.hex1 = 7'b1111111;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer.
// dut0 runs with AUTO_RELOAD=0, dut1 with AUTO_RELOAD=1; both share clk/clear_b.
module tb_countdown_timer;

   logic clk = 1'b0;
   logic clear_b = 1'b0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

`ifdef COUNTDOWN_SEG_EN
   localparam logic [6:0] HEX_0 = 7'b1000000;
   localparam logic [6:0] HEX_A = 7'b0001000;
   localparam logic [6:0] HEX_F = 7'b0001110;
`else
   localparam logic [6:0] HEX_0 = 7'b1111111;
   localparam logic [6:0] HEX_A = 7'b1111111;
   localparam logic [6:0] HEX_F = 7'b1111111;
`endif

   countdown_timer_if bus0();
   countdown_timer_if bus1();

   countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .clear_b(clear_b), .bus(bus0.slave));
   countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .clear_b(clear_b), .bus(bus1.slave));

   // 10 ns clock period.
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      total_cnt++; if (bus0.q !== 8'h00) $display("FAIL reset_q: got %h exp %h", bus0.q, 8'h00); else pass_cnt++;
      total_cnt++; if (bus0.tc !== 1'b0) $display("FAIL reset_tc: got %b exp 0", bus0.tc); else pass_cnt++;
      total_cnt++; if (bus0.running !== 1'b0) $display("FAIL reset_running: got %b exp 0", bus0.running); else pass_cnt++;
      total_cnt++; if (bus0.hex0 !== HEX_0) $display("FAIL reset_hex0: got %b exp %b", bus0.hex0, HEX_0); else pass_cnt++;
      total_cnt++; if (bus0.hex1 !== HEX_0) $display("FAIL reset_hex1: got %b exp %b", bus0.hex1, HEX_0); else pass_cnt++;
      clear_b = 1'b1;
      bus0.enable = 1'b1;
      step();
      // IDLE ignores enable.
      total_cnt++; if (bus0.q !== 8'h00) $display("FAIL idle_q: got %h exp %h", bus0.q, 8'h00); else pass_cnt++;
      total_cnt++; if (bus0.running !== 1'b0) $display("FAIL idle_running: got %b exp 0", bus0.running); else pass_cnt++;
      bus0.enable = 1'b0;
   endtask

   task automatic test_basic_run();
      logic [7:0] exp_q  [6] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
      logic       exp_tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       exp_run[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      bus0.load = 1'b1; bus0.load_value = 8'h03;
      for (int i = 0; i < 6; i++) begin
         step();
         bus0.load = 1'b0; bus0.enable = 1'b1;
         total_cnt++; if (bus0.q !== exp_q[i]) $display("FAIL run_q[%0d]: got %h exp %h", i, bus0.q, exp_q[i]); else pass_cnt++;
         total_cnt++; if (bus0.tc !== exp_tc[i]) $display("FAIL run_tc[%0d]: got %b exp %b", i, bus0.tc, exp_tc[i]); else pass_cnt++;
         total_cnt++; if (bus0.running !== exp_run[i]) $display("FAIL run_running[%0d]: got %b exp %b", i, bus0.running, exp_run[i]); else pass_cnt++;
      end
      bus0.enable = 1'b0;
   endtask

   task automatic test_priority();
      bus0.load = 1'b1; bus0.load_value = 8'h05;
      step();
      bus0.load_value = 8'h09; bus0.enable = 1'b1;
      step();
      total_cnt++; if (bus0.q !== 8'h09) $display("FAIL prio_load_wins: got %h exp %h", bus0.q, 8'h09); else pass_cnt++;
      bus0.load = 1'b0;
      step();
      total_cnt++; if (bus0.q !== 8'h08) $display("FAIL prio_next_dec: got %h exp %h", bus0.q, 8'h08); else pass_cnt++;
      bus0.enable = 1'b0;
      step();
      total_cnt++; if (bus0.q !== 8'h08) $display("FAIL hold_q: got %h exp %h", bus0.q, 8'h08); else pass_cnt++;
      total_cnt++; if (bus0.running !== 1'b1) $display("FAIL hold_running: got %b exp 1", bus0.running); else pass_cnt++;
   endtask

   task automatic test_zero_load();
      bus0.load = 1'b1; bus0.load_value = 8'h00;
      step();
      bus0.load = 1'b0; bus0.enable = 1'b1;
      total_cnt++; if (bus0.running !== 1'b0) $display("FAIL zero_running: got %b exp 0", bus0.running); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         step();
         total_cnt++; if (bus0.q !== 8'h00) $display("FAIL zero_q[%0d]: got %h exp 00", i, bus0.q); else pass_cnt++;
         total_cnt++; if (bus0.tc !== 1'b0) $display("FAIL zero_tc[%0d]: got %b exp 0", i, bus0.tc); else pass_cnt++;
      end
      bus0.enable = 1'b0;
   endtask

   task automatic test_load_one();
      bus0.load = 1'b1; bus0.load_value = 8'h01;
      step();
      bus0.load = 1'b0; bus0.enable = 1'b1;
      step();
      total_cnt++; if (bus0.q !== 8'h00) $display("FAIL one_q: got %h exp 00", bus0.q); else pass_cnt++;
      total_cnt++; if (bus0.tc !== 1'b1) $display("FAIL one_tc: got %b exp 1", bus0.tc); else pass_cnt++;
      bus0.enable = 1'b0;
   endtask

   task automatic test_auto_reload();
      logic [7:0] exp_q  [6] = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02};
      logic       exp_tc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bus1.load = 1'b1; bus1.load_value = 8'h02;
      step();
      bus1.load = 1'b0; bus1.enable = 1'b1;
      total_cnt++; if (bus1.q !== 8'h02) $display("FAIL ar_load_q: got %h exp 02", bus1.q); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         step();
         total_cnt++; if (bus1.q !== exp_q[i]) $display("FAIL ar_q[%0d]: got %h exp %h", i, bus1.q, exp_q[i]); else pass_cnt++;
         total_cnt++; if (bus1.tc !== exp_tc[i]) $display("FAIL ar_tc[%0d]: got %b exp %b", i, bus1.tc, exp_tc[i]); else pass_cnt++;
         total_cnt++; if (bus1.running !== 1'b1) $display("FAIL ar_running[%0d]: got %b exp 1", i, bus1.running); else pass_cnt++;
      end
      bus1.enable = 1'b0;
      step();
      total_cnt++; if (bus1.q !== 8'h02) $display("FAIL ar_hold_q: got %h exp 02", bus1.q); else pass_cnt++;
      total_cnt++; if (bus1.tc !== 1'b0) $display("FAIL ar_hold_tc: got %b exp 0", bus1.tc); else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      bus1.load = 1'b1; bus1.load_value = 8'h01;
      bus0.load = 1'b1; bus0.load_value = 8'h20;
      step();
      bus0.load = 1'b0; bus0.enable = 1'b1;
      bus1.load = 1'b0; bus1.enable = 1'b1;
      for (int i = 0; i < 5; i++) step();
      total_cnt++; if (bus0.q !== 8'h1B) $display("FAIL mid_q_before: got %h exp 1b", bus0.q); else pass_cnt++;
      total_cnt++; if (bus1.tc !== 1'b1) $display("FAIL mid_tc_before: got %b exp 1", bus1.tc); else pass_cnt++;
      clear_b = 1'b0;
      #1;
      total_cnt++; if (bus0.q !== 8'h00) $display("FAIL mid_q: got %h exp 00", bus0.q); else pass_cnt++;
      total_cnt++; if (bus0.running !== 1'b0) $display("FAIL mid_running: got %b exp 0", bus0.running); else pass_cnt++;
      total_cnt++; if (bus1.tc !== 1'b0) $display("FAIL mid_tc: got %b exp 0", bus1.tc); else pass_cnt++;
      total_cnt++; if (bus0.hex0 !== HEX_0) $display("FAIL mid_hex0: got %b exp %b", bus0.hex0, HEX_0); else pass_cnt++;
      total_cnt++; if (bus0.hex1 !== HEX_0) $display("FAIL mid_hex1: got %b exp %b", bus0.hex1, HEX_0); else pass_cnt++;
      clear_b = 1'b1;
      step();
      // Back in IDLE: enable is ignored.
      total_cnt++; if (bus0.q !== 8'h00) $display("FAIL mid_idle_q: got %h exp 00", bus0.q); else pass_cnt++;
      total_cnt++; if (bus0.running !== 1'b0) $display("FAIL mid_idle_running: got %b exp 0", bus0.running); else pass_cnt++;
      bus0.enable = 1'b0; bus1.enable = 1'b0;
   endtask

   task automatic test_display();
      bus0.load = 1'b1; bus0.load_value = 8'hAF;
      step();
      bus0.load = 1'b0;
      total_cnt++; if (bus0.q !== 8'hAF) $display("FAIL disp_q: got %h exp af", bus0.q); else pass_cnt++;
      total_cnt++; if (bus0.hex1 !== HEX_A) $display("FAIL disp_hex1: got %b exp %b", bus0.hex1, HEX_A); else pass_cnt++;
      total_cnt++; if (bus0.hex0 !== HEX_F) $display("FAIL disp_hex0: got %b exp %b", bus0.hex0, HEX_F); else pass_cnt++;
   endtask

   initial begin
      bus0.enable = 1'b0; bus0.load = 1'b0; bus0.load_value = 8'h00;
      bus1.enable = 1'b0; bus1.load = 1'b0; bus1.load_value = 8'h00;
      test_reset();
      test_basic_run();
      test_priority();
      test_zero_load();
      test_load_one();
      test_auto_reload();
      test_reset_mid_run();
      test_display();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
